// File: rtl/exec_unit_md_pkg.sv
// Shared decode constants, FSM state type and op-field layout for exec_unit_md.
package exec_unit_md_pkg;

  // RV32I major opcodes handled by the unit
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_IMM    = 7'b0010011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;

  // Integer ALU funct3 codes (OP and OP-IMM)
  localparam logic [2:0] F3_ADD  = 3'd0;
  localparam logic [2:0] F3_SLL  = 3'd1;
  localparam logic [2:0] F3_SLT  = 3'd2;
  localparam logic [2:0] F3_SLTU = 3'd3;
  localparam logic [2:0] F3_XOR  = 3'd4;
  localparam logic [2:0] F3_SR   = 3'd5;
  localparam logic [2:0] F3_OR   = 3'd6;
  localparam logic [2:0] F3_AND  = 3'd7;

  // Branch compare funct3 codes
  localparam logic [2:0] F3_BEQ  = 3'd0;
  localparam logic [2:0] F3_BNE  = 3'd1;
  localparam logic [2:0] F3_BLT  = 3'd4;
  localparam logic [2:0] F3_BGE  = 3'd5;
  localparam logic [2:0] F3_BLTU = 3'd6;
  localparam logic [2:0] F3_BGEU = 3'd7;

  // M-extension funct3 codes
  localparam logic [2:0] F3_MUL    = 3'd0;
  localparam logic [2:0] F3_MULH   = 3'd1;
  localparam logic [2:0] F3_MULHSU = 3'd2;
  localparam logic [2:0] F3_MULHU  = 3'd3;
  localparam logic [2:0] F3_DIV    = 3'd4;
  localparam logic [2:0] F3_DIVU   = 3'd5;
  localparam logic [2:0] F3_REM    = 3'd6;
  localparam logic [2:0] F3_REMU   = 3'd7;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_MUL  = 2'd1,
    ST_DIV  = 2'd2
  } state_e;

  // Field layout of the 12-bit op bus
  typedef struct packed {
    logic       f7_b0;
    logic       f7_b5;
    logic [2:0] funct3;
    logic [6:0] opcode;
  } op_t;

  // R-type with funct7 bit0 set selects the M extension
  function automatic logic is_mext(input op_t o);
    return (o.opcode == OPC_OP) && o.f7_b0;
  endfunction

endpackage

// File: rtl/exec_unit_md_div_iter.sv
// Iterative radix-2 restoring unsigned divider; one quotient bit per cycle,
// XLEN cycles per divide. The first bit is produced on the start edge.
module exec_unit_md_div_iter
  import exec_unit_md_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic            clk_in,
  input  logic            rstn_in,
  input  logic            clear,
  input  logic            start,
  input  logic [XLEN-1:0] dividend,
  input  logic [XLEN-1:0] divisor,
  output logic            done,
  output logic [XLEN-1:0] quotient,
  output logic [XLEN-1:0] remainder
);

  localparam int CW = $clog2(XLEN) + 1;

  logic            busy_q, busy_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [XLEN-1:0] rem_q, rem_d;
  logic [XLEN-1:0] quo_q, quo_d;
  logic [XLEN-1:0] dvs_q, dvs_d;

  logic [XLEN-1:0] src_rem, src_quo, src_dvs;
  logic [XLEN:0]   shifted, trial;
  logic [XLEN-1:0] step_rem, step_quo;

  // One restoring step on either fresh operands (start) or the running state
  always_comb begin
    src_rem  = start ? '0 : rem_q;
    src_quo  = start ? dividend : quo_q;
    src_dvs  = start ? divisor : dvs_q;
    shifted  = {src_rem, src_quo[XLEN-1]};
    trial    = shifted - {1'b0, src_dvs};
    step_rem = trial[XLEN] ? shifted[XLEN-1:0] : trial[XLEN-1:0];
    step_quo = {src_quo[XLEN-2:0], ~trial[XLEN]};
  end

  // Sequencing: clear aborts, start loads, busy iterates until XLEN bits are done
  always_comb begin
    busy_d = busy_q;
    cnt_d  = cnt_q;
    rem_d  = rem_q;
    quo_d  = quo_q;
    dvs_d  = dvs_q;
    if (clear) begin
      busy_d = 1'b0;
      cnt_d  = '0;
    end else if (start) begin
      busy_d = 1'b1;
      cnt_d  = CW'(1);
      rem_d  = step_rem;
      quo_d  = step_quo;
      dvs_d  = divisor;
    end else if (busy_q) begin
      if (cnt_q == CW'(XLEN)) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CW'(1);
        rem_d = step_rem;
        quo_d = step_quo;
      end
    end
  end

  // Divider state registers
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      busy_q <= 1'b0;
      cnt_q  <= '0;
      rem_q  <= '0;
      quo_q  <= '0;
      dvs_q  <= '0;
    end else begin
      busy_q <= busy_d;
      cnt_q  <= cnt_d;
      rem_q  <= rem_d;
      quo_q  <= quo_d;
      dvs_q  <= dvs_d;
    end
  end

  assign done      = busy_q && (cnt_q == CW'(XLEN));
  assign quotient  = quo_q;
  assign remainder = rem_q;

endmodule

// File: rtl/exec_unit_md.sv
// Integer execute unit: single-cycle RV32I ALU/branch/jump ops, pipelined
// multiply and iterative divide, with a flush that squashes in-flight work.
// Legal parameters: XLEN 32 or 64, MUL_LAT >= 1.
module exec_unit_md
  import exec_unit_md_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int ROB_W   = 4,
  parameter int MUL_LAT = 2
) (
  input  logic             clk_in,
  input  logic             rstn_in,
  input  logic             flush_in,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [11:0]      op,
  input  logic [XLEN-1:0]  v1,
  input  logic [XLEN-1:0]  v2,
  input  logic [XLEN-1:0]  pc,
  input  logic [XLEN-1:0]  imm,
  input  logic             is_short,
  input  logic [ROB_W-1:0] in_rob_id,
  output logic             has_output,
  output logic [ROB_W-1:0] rob_id,
  output logic [XLEN-1:0]  value,
  output logic             has_new_pc,
  output logic [XLEN-1:0]  new_pc
);

  localparam int SHW       = $clog2(XLEN);
  localparam int MCW       = (MUL_LAT > 1) ? $clog2(MUL_LAT) : 1;
  localparam int MUL_DEPTH = (MUL_LAT > 1) ? MUL_LAT - 1 : 1;
  localparam int MUL_TAP   = MUL_DEPTH - 1;

  op_t op_f;
  assign op_f = op_t'(op);

  state_e           state_q, state_d;
  logic [MCW-1:0]   mul_cnt_q, mul_cnt_d;
  logic [XLEN-1:0]  mul_pipe_q [MUL_DEPTH];
  logic [XLEN-1:0]  mul_pipe_d [MUL_DEPTH];
  logic [ROB_W-1:0] pend_rob_q, pend_rob_d;
  logic             quo_neg_q, quo_neg_d;
  logic             rem_neg_q, rem_neg_d;
  logic             is_rem_q, is_rem_d;
  logic             has_output_q, has_output_d;
  logic             has_new_pc_q, has_new_pc_d;
  logic [ROB_W-1:0] rob_id_q, rob_id_d;
  logic [XLEN-1:0]  value_q, value_d;
  logic [XLEN-1:0]  new_pc_q, new_pc_d;

  logic             accept;
  logic [XLEN-1:0]  alu_result, link, jalr_target;
  logic             is_jalr;
  logic [SHW-1:0]   sh_imm, sh_reg;

  logic [2*XLEN-1:0] mul_a, mul_b, product;
  logic [XLEN-1:0]   mul_result;

  logic             div_signed, div_is_rem, v1_neg, v2_neg;
  logic             div_by_zero, div_overflow;
  logic [XLEN-1:0]  div_a, div_b, div_fast_value;
  logic             div_start, div_clear, div_done;
  logic [XLEN-1:0]  div_quo, div_rem, div_final;

  assign in_ready = (state_q == ST_IDLE);
  assign accept   = in_valid && in_ready && !flush_in;
  assign sh_imm   = imm[SHW-1:0];
  assign sh_reg   = v2[SHW-1:0];

  // Single-cycle ALU, branch compare and link/target computation
  always_comb begin
    alu_result  = '0;
    is_jalr     = 1'b0;
    link        = pc + (is_short ? XLEN'(2) : XLEN'(4));
    jalr_target = (v1 + imm) & ~XLEN'(1);
    case (op_f.opcode)
      OPC_LUI:   alu_result = imm;
      OPC_AUIPC: alu_result = pc + imm;
      OPC_JAL:   alu_result = link;
      OPC_JALR: begin
        alu_result = link;
        is_jalr    = 1'b1;
      end
      OPC_BRANCH: begin
        case (op_f.funct3)
          F3_BEQ:  alu_result = XLEN'(v1 == v2);
          F3_BNE:  alu_result = XLEN'(v1 != v2);
          F3_BLT:  alu_result = XLEN'($signed(v1) < $signed(v2));
          F3_BGE:  alu_result = XLEN'($signed(v1) >= $signed(v2));
          F3_BLTU: alu_result = XLEN'(v1 < v2);
          F3_BGEU: alu_result = XLEN'(v1 >= v2);
          default: alu_result = '0;
        endcase
      end
      OPC_IMM: begin
        case (op_f.funct3)
          F3_ADD:  alu_result = v1 + imm;
          F3_SLL:  alu_result = v1 << sh_imm;
          F3_SLT:  alu_result = XLEN'($signed(v1) < $signed(imm));
          F3_SLTU: alu_result = XLEN'(v1 < imm);
          F3_XOR:  alu_result = v1 ^ imm;
          F3_SR:   alu_result = op_f.f7_b5 ? $unsigned($signed(v1) >>> sh_imm) : (v1 >> sh_imm);
          F3_OR:   alu_result = v1 | imm;
          default: alu_result = v1 & imm;
        endcase
      end
      OPC_OP: begin
        case (op_f.funct3)
          F3_ADD:  alu_result = op_f.f7_b5 ? (v1 - v2) : (v1 + v2);
          F3_SLL:  alu_result = v1 << sh_reg;
          F3_SLT:  alu_result = XLEN'($signed(v1) < $signed(v2));
          F3_SLTU: alu_result = XLEN'(v1 < v2);
          F3_XOR:  alu_result = v1 ^ v2;
          F3_SR:   alu_result = op_f.f7_b5 ? $unsigned($signed(v1) >>> sh_reg) : (v1 >> sh_reg);
          F3_OR:   alu_result = v1 | v2;
          default: alu_result = v1 & v2;
        endcase
      end
      default: alu_result = '0;
    endcase
  end

  // Full 2*XLEN product with per-operand sign extension, then half select
  always_comb begin
    mul_a = ((op_f.funct3 == F3_MULH) || (op_f.funct3 == F3_MULHSU)) ?
            {{XLEN{v1[XLEN-1]}}, v1} : {{XLEN{1'b0}}, v1};
    mul_b = (op_f.funct3 == F3_MULH) ? {{XLEN{v2[XLEN-1]}}, v2} : {{XLEN{1'b0}}, v2};
    product    = mul_a * mul_b;
    mul_result = (op_f.funct3 == F3_MUL) ? product[XLEN-1:0] : product[2*XLEN-1:XLEN];
  end

  // Divide operand preparation: magnitudes, corner cases and fast-path value
  always_comb begin
    div_signed     = !op_f.funct3[0];
    div_is_rem     = op_f.funct3[1];
    v1_neg         = div_signed && v1[XLEN-1];
    v2_neg         = div_signed && v2[XLEN-1];
    div_a          = v1_neg ? (~v1 + XLEN'(1)) : v1;
    div_b          = v2_neg ? (~v2 + XLEN'(1)) : v2;
    div_by_zero    = (v2 == '0);
    div_overflow   = div_signed && (v1 == {1'b1, {(XLEN-1){1'b0}}}) && (v2 == '1);
    div_fast_value = '0;
    if (div_by_zero) begin
      div_fast_value = div_is_rem ? v1 : '1;
    end else if (div_overflow) begin
      div_fast_value = div_is_rem ? '0 : v1;
    end
    div_final = is_rem_q ? (rem_neg_q ? (~div_rem + XLEN'(1)) : div_rem)
                         : (quo_neg_q ? (~div_quo + XLEN'(1)) : div_quo);
  end

  // Next-state: accept and dispatch in IDLE, count out MUL, wait for divider
  always_comb begin
    state_d      = state_q;
    mul_cnt_d    = mul_cnt_q;
    pend_rob_d   = pend_rob_q;
    quo_neg_d    = quo_neg_q;
    rem_neg_d    = rem_neg_q;
    is_rem_d     = is_rem_q;
    has_output_d = 1'b0;
    has_new_pc_d = 1'b0;
    rob_id_d     = rob_id_q;
    value_d      = value_q;
    new_pc_d     = new_pc_q;
    div_start    = 1'b0;
    div_clear    = 1'b0;
    mul_pipe_d[0] = mul_pipe_q[0];
    for (int i = 1; i < MUL_DEPTH; i++) begin
      mul_pipe_d[i] = mul_pipe_q[i-1];
    end

    if (flush_in) begin
      state_d   = ST_IDLE;
      mul_cnt_d = '0;
      div_clear = 1'b1;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (accept) begin
            if (is_mext(op_f)) begin
              if (!op_f.funct3[2]) begin
                if (MUL_LAT == 1) begin
                  has_output_d = 1'b1;
                  value_d      = mul_result;
                  rob_id_d     = in_rob_id;
                end else begin
                  state_d       = ST_MUL;
                  mul_cnt_d     = MCW'(MUL_LAT - 1);
                  mul_pipe_d[0] = mul_result;
                  pend_rob_d    = in_rob_id;
                end
              end else if (div_by_zero || div_overflow) begin
                has_output_d = 1'b1;
                value_d      = div_fast_value;
                rob_id_d     = in_rob_id;
              end else begin
                state_d    = ST_DIV;
                div_start  = 1'b1;
                pend_rob_d = in_rob_id;
                quo_neg_d  = v1_neg ^ v2_neg;
                rem_neg_d  = v1_neg;
                is_rem_d   = div_is_rem;
              end
            end else begin
              has_output_d = 1'b1;
              value_d      = alu_result;
              rob_id_d     = in_rob_id;
              if (is_jalr) begin
                has_new_pc_d = 1'b1;
                new_pc_d     = jalr_target;
              end
            end
          end
        end
        ST_MUL: begin
          mul_cnt_d = mul_cnt_q - MCW'(1);
          if (mul_cnt_q == MCW'(1)) begin
            state_d      = ST_IDLE;
            mul_cnt_d    = '0;
            has_output_d = 1'b1;
            value_d      = mul_pipe_q[MUL_TAP];
            rob_id_d     = pend_rob_q;
          end
        end
        ST_DIV: begin
          if (div_done) begin
            state_d      = ST_IDLE;
            has_output_d = 1'b1;
            value_d      = div_final;
            rob_id_d     = pend_rob_q;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // All unit state and registered outputs
  always_ff @(posedge clk_in or negedge rstn_in) begin
    if (!rstn_in) begin
      state_q      <= ST_IDLE;
      mul_cnt_q    <= '0;
      pend_rob_q   <= '0;
      quo_neg_q    <= 1'b0;
      rem_neg_q    <= 1'b0;
      is_rem_q     <= 1'b0;
      has_output_q <= 1'b0;
      has_new_pc_q <= 1'b0;
      rob_id_q     <= '0;
      value_q      <= '0;
      new_pc_q     <= '0;
      for (int i = 0; i < MUL_DEPTH; i++) begin
        mul_pipe_q[i] <= '0;
      end
    end else begin
      state_q      <= state_d;
      mul_cnt_q    <= mul_cnt_d;
      pend_rob_q   <= pend_rob_d;
      quo_neg_q    <= quo_neg_d;
      rem_neg_q    <= rem_neg_d;
      is_rem_q     <= is_rem_d;
      has_output_q <= has_output_d;
      has_new_pc_q <= has_new_pc_d;
      rob_id_q     <= rob_id_d;
      value_q      <= value_d;
      new_pc_q     <= new_pc_d;
      for (int i = 0; i < MUL_DEPTH; i++) begin
        mul_pipe_q[i] <= mul_pipe_d[i];
      end
    end
  end

  exec_unit_md_div_iter #(
    .XLEN(XLEN)
  ) u_div (
    .clk_in   (clk_in),
    .rstn_in  (rstn_in),
    .clear    (div_clear),
    .start    (div_start),
    .dividend (div_a),
    .divisor  (div_b),
    .done     (div_done),
    .quotient (div_quo),
    .remainder(div_rem)
  );

  assign has_output = has_output_q;
  assign has_new_pc = has_new_pc_q;
  assign rob_id     = rob_id_q;
  assign value      = value_q;
  assign new_pc     = new_pc_q;

endmodule

// File: tb/tb_exec_unit_md.sv
// Randomised scoreboard bench for exec_unit_md with a behavioural reference model.
module tb_exec_unit_md;

   localparam int XLEN    = 32;
   localparam int ROB_W   = 4;
   localparam int MUL_LAT = 2;

   logic              clk_in = 1'b0;
   logic              rstn_in;
   logic              flush_in;
   logic              in_valid;
   logic              in_ready;
   logic [11:0]       op;
   logic [XLEN-1:0]   v1, v2, pc, imm;
   logic              is_short;
   logic [ROB_W-1:0]  in_rob_id;
   logic              has_output;
   logic [ROB_W-1:0]  rob_id;
   logic [XLEN-1:0]   value;
   logic              has_new_pc;
   logic [XLEN-1:0]   new_pc;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;

   typedef struct {
      logic [ROB_W-1:0] rob;
      logic [XLEN-1:0]  value;
      bit               npc;
      logic [XLEN-1:0]  new_pc;
      int               cyc;
   } exp_t;

   exp_t sb[$];
   exp_t monE;

   exec_unit_md #(.XLEN(XLEN), .ROB_W(ROB_W), .MUL_LAT(MUL_LAT)) dut (
      .clk_in    (clk_in),
      .rstn_in   (rstn_in),
      .flush_in  (flush_in),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .op        (op),
      .v1        (v1),
      .v2        (v2),
      .pc        (pc),
      .imm       (imm),
      .is_short  (is_short),
      .in_rob_id (in_rob_id),
      .has_output(has_output),
      .rob_id    (rob_id),
      .value     (value),
      .has_new_pc(has_new_pc),
      .new_pc    (new_pc)
   );

   // free-running clock and a cycle counter stepped on every rising edge
   always #5 clk_in = ~clk_in;
   always @(posedge clk_in) cyc++;

   // one comparison, counted, with a FAIL line on mismatch
   task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("[TB] FAIL %s: got 0x%0h expected 0x%0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic logic [11:0] mkOp(input bit m, input bit b5, input logic [2:0] f3, input logic [6:0] opc);
      return {m, b5, f3, opc};
   endfunction

   // integer ALU semantics on 32-bit operands
   function automatic logic [31:0] aluRef(input logic [31:0] a, input logic [31:0] b,
                                          input logic [2:0] f3, input bit sub, input bit arith);
      longint sa = longint'($signed(a));
      longint sbv = longint'($signed(b));
      int sh = int'(b[4:0]);
      case (f3)
         3'd0: return sub ? a - b : a + b;
         3'd1: return a << sh;
         3'd2: return (sa < sbv) ? 32'd1 : 32'd0;
         3'd3: return (a < b) ? 32'd1 : 32'd0;
         3'd4: return a ^ b;
         3'd5: return arith ? 32'($signed(a) >>> sh) : (a >> sh);
         3'd6: return a | b;
         default: return a & b;
      endcase
   endfunction

   // behavioural reference: result, redirect and latency for one op
   function automatic void refModel(input logic [11:0] o, input logic [31:0] a, input logic [31:0] b,
                                    input logic [31:0] p, input logic [31:0] im, input bit sh,
                                    output logic [31:0] res, output bit npc, output logic [31:0] tgt,
                                    output int lat);
      logic [6:0] opc = o[6:0];
      logic [2:0] f3 = o[9:7];
      bit b5 = o[10];
      bit m = o[11];
      longint sa = longint'($signed(a));
      longint sbv = longint'($signed(b));
      longint unsigned ua = longint'(a);
      longint unsigned ub = longint'(b);
      logic [63:0] prod;
      res = 32'd0; npc = 1'b0; tgt = 32'd0; lat = 1;
      case (opc)
         7'h37: res = im;
         7'h17: res = p + im;
         7'h6F: res = p + (sh ? 32'd2 : 32'd4);
         7'h67: begin
            res = p + (sh ? 32'd2 : 32'd4);
            npc = 1'b1;
            tgt = (a + im) & 32'hFFFF_FFFE;
         end
         7'h63: case (f3)
            3'd0: res = (a == b) ? 32'd1 : 32'd0;
            3'd1: res = (a != b) ? 32'd1 : 32'd0;
            3'd4: res = (sa < sbv) ? 32'd1 : 32'd0;
            3'd5: res = (sa >= sbv) ? 32'd1 : 32'd0;
            3'd6: res = (ua < ub) ? 32'd1 : 32'd0;
            3'd7: res = (ua >= ub) ? 32'd1 : 32'd0;
            default: res = 32'd0;
         endcase
         7'h13: res = aluRef(a, im, f3, 1'b0, b5);
         7'h33: begin
            if (!m) begin
               res = aluRef(a, b, f3, b5, b5);
            end else begin
               case (f3)
                  3'd0: begin prod = 64'(sa * sbv); res = prod[31:0]; end
                  3'd1: begin prod = 64'(sa * sbv); res = prod[63:32]; end
                  3'd2: begin prod = 64'(sa * longint'(ub)); res = prod[63:32]; end
                  3'd3: begin prod = 64'(ua * ub); res = prod[63:32]; end
                  3'd4: begin
                     if (b == 0) res = 32'hFFFF_FFFF;
                     else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = a;
                     else begin res = 32'(sa / sbv); lat = XLEN + 1; end
                  end
                  3'd5: begin
                     if (b == 0) res = 32'hFFFF_FFFF;
                     else begin res = 32'(ua / ub); lat = XLEN + 1; end
                  end
                  3'd6: begin
                     if (b == 0) res = a;
                     else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) res = 32'd0;
                     else begin res = 32'(sa % sbv); lat = XLEN + 1; end
                  end
                  default: begin
                     if (b == 0) res = a;
                     else begin res = 32'(ua % ub); lat = XLEN + 1; end
                  end
               endcase
               if (f3 < 3'd4) lat = MUL_LAT;
            end
         end
         default: res = 32'd0;
      endcase
   endfunction

   // present one op at a falling edge, hold until accepted, log the expected response
   task automatic applyStimulus(input logic [11:0] o, input logic [31:0] a, input logic [31:0] b,
                                input logic [31:0] p, input logic [31:0] im, input bit sh,
                                input logic [3:0] rob, input bit useExp, input logic [31:0] expVal);
      logic [31:0] res, tgt;
      bit npc;
      int lat;
      int waited = 0;
      op = o; v1 = a; v2 = b; pc = p; imm = im; is_short = sh; in_rob_id = rob;
      in_valid = 1'b1;
      while (!in_ready && waited < 200) begin
         @(negedge clk_in);
         waited++;
      end
      if (!in_ready) begin
         checkOutput("ready_timeout", 64'(in_ready), 64'd1);
         in_valid = 1'b0;
         return;
      end
      refModel(o, a, b, p, im, sh, res, npc, tgt, lat);
      if (useExp) res = expVal;
      sb.push_back('{rob, res, npc, tgt, cyc + lat});
      @(negedge clk_in);
      in_valid = 1'b0;
   endtask

   task automatic measureReadyLow(output int n);
      n = 0;
      while (!in_ready && n < 200) begin
         @(negedge clk_in);
         n++;
      end
   endtask

   task automatic idleCycles(input int n);
      repeat (n) @(negedge clk_in);
   endtask

   function automatic logic [31:0] rndVal();
      case ($urandom_range(0, 7))
         0: return 32'd0;
         1: return 32'd1;
         2: return 32'hFFFF_FFFF;
         3: return 32'h8000_0000;
         4: return 32'h7FFF_FFFF;
         default: return $urandom;
      endcase
   endfunction

   // monitor: pop and compare whenever the unit presents a result
   always @(negedge clk_in) begin
      if (rstn_in) begin
         if (has_new_pc && !has_output) checkOutput("npc_without_output", 64'd1, 64'd0);
         if (has_output) begin
            if (sb.size() == 0) begin
               checkOutput("unexpected_output", 64'd1, 64'd0);
            end else begin
               monE = sb.pop_front();
               checkOutput("value", 64'(value), 64'(monE.value));
               checkOutput("rob_id", 64'(rob_id), 64'(monE.rob));
               checkOutput("has_new_pc", 64'(has_new_pc), 64'(monE.npc));
               if (monE.npc) checkOutput("new_pc", 64'(new_pc), 64'(monE.new_pc));
               checkOutput("latency", 64'(cyc), 64'(monE.cyc));
            end
         end
      end
   end

   initial begin
      #3_000_000;
      $display("[TB] FAIL watchdog: got timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

   initial begin
      int n;
      int waited;
      logic [11:0] o;
      logic [31:0] a, b, im, p;
      rstn_in = 1'b0; flush_in = 1'b0; in_valid = 1'b0;
      op = '0; v1 = '0; v2 = '0; pc = '0; imm = '0; is_short = 1'b0; in_rob_id = '0;

      // reset state
      idleCycles(3);
      checkOutput("rst_has_output", 64'(has_output), 64'd0);
      checkOutput("rst_has_new_pc", 64'(has_new_pc), 64'd0);
      checkOutput("rst_rob_id", 64'(rob_id), 64'd0);
      checkOutput("rst_value", 64'(value), 64'd0);
      checkOutput("rst_new_pc", 64'(new_pc), 64'd0);
      rstn_in = 1'b1;
      @(negedge clk_in);
      checkOutput("ready_after_reset", 64'(in_ready), 64'd1);

      // ADDI then back-to-back SUB
      applyStimulus(mkOp(0, 0, 3'd0, 7'h13), 32'd5, 32'd0, 32'd0, 32'hFFFF_FFF9, 0, 4'd3, 1, 32'hFFFF_FFFE);
      applyStimulus(mkOp(0, 1, 3'd0, 7'h33), 32'd10, 32'd3, 32'd0, 32'd0, 0, 4'd4, 1, 32'd7);
      idleCycles(1);

      // JALR with compressed link
      applyStimulus(mkOp(0, 0, 3'd0, 7'h67), 32'h1001, 32'd0, 32'h100, 32'd4, 1, 4'd5, 1, 32'h102);
      idleCycles(2);

      // MULH / MULHU
      applyStimulus(mkOp(1, 0, 3'd1, 7'h33), 32'h8000_0000, 32'd2, 32'd0, 32'd0, 0, 4'd6, 1, 32'hFFFF_FFFF);
      measureReadyLow(n);
      checkOutput("mul_ready_low", 64'(n), 64'(MUL_LAT - 1));
      applyStimulus(mkOp(1, 0, 3'd3, 7'h33), 32'h8000_0000, 32'd2, 32'd0, 32'd0, 0, 4'd7, 1, 32'd1);
      measureReadyLow(n);

      // DIV / REM of -7 by 2
      applyStimulus(mkOp(1, 0, 3'd4, 7'h33), 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 0, 4'd8, 1, 32'hFFFF_FFFD);
      measureReadyLow(n);
      checkOutput("div_ready_low", 64'(n), 64'(XLEN));
      applyStimulus(mkOp(1, 0, 3'd6, 7'h33), 32'hFFFF_FFF9, 32'd2, 32'd0, 32'd0, 0, 4'd9, 1, 32'hFFFF_FFFF);
      measureReadyLow(n);

      // divide fast paths
      applyStimulus(mkOp(1, 0, 3'd5, 7'h33), 32'd9, 32'd0, 32'd0, 32'd0, 0, 4'd10, 1, 32'hFFFF_FFFF);
      measureReadyLow(n);
      checkOutput("divz_ready_low", 64'(n), 64'd0);
      applyStimulus(mkOp(1, 0, 3'd4, 7'h33), 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 0, 4'd11, 1, 32'h8000_0000);
      applyStimulus(mkOp(1, 0, 3'd6, 7'h33), 32'h8000_0000, 32'hFFFF_FFFF, 32'd0, 32'd0, 0, 4'd12, 1, 32'd0);
      idleCycles(2);

      // flush mid-divide with a new op presented in the flush cycle
      applyStimulus(mkOp(1, 0, 3'd4, 7'h33), 32'd1000, 32'd7, 32'd0, 32'd0, 0, 4'd13, 0, 32'd0);
      idleCycles(8);
      sb.delete();
      op = mkOp(0, 0, 3'd0, 7'h13); v1 = 32'd1; imm = 32'd1; in_rob_id = 4'd14;
      in_valid = 1'b1; flush_in = 1'b1;
      @(negedge clk_in);
      in_valid = 1'b0; flush_in = 1'b0;
      checkOutput("ready_after_flush", 64'(in_ready), 64'd1);
      idleCycles(40);

      // reset mid-divide
      applyStimulus(mkOp(0, 0, 3'd0, 7'h13), 32'h50, 32'd0, 32'd0, 32'h5, 0, 4'd15, 1, 32'h55);
      idleCycles(1);
      applyStimulus(mkOp(1, 0, 3'd5, 7'h33), 32'd12345, 32'd10, 32'd0, 32'd0, 0, 4'd1, 0, 32'd0);
      idleCycles(5);
      rstn_in = 1'b0;
      sb.delete();
      #1;
      checkOutput("midrst_has_output", 64'(has_output), 64'd0);
      checkOutput("midrst_value", 64'(value), 64'd0);
      checkOutput("midrst_rob_id", 64'(rob_id), 64'd0);
      idleCycles(2);
      rstn_in = 1'b1;
      @(negedge clk_in);
      checkOutput("ready_after_midrst", 64'(in_ready), 64'd1);
      idleCycles(40);

      // randomised traffic
      for (int k = 0; k < 200; k++) begin
         a = rndVal(); b = rndVal(); im = rndVal(); p = $urandom & 32'hFFFF_FFFE;
         case ($urandom_range(0, 9))
            0: o = mkOp(0, 0, 3'($urandom), 7'h37);
            1: o = mkOp(0, 0, 3'($urandom), 7'h17);
            2: o = mkOp(0, 0, 3'($urandom), 7'h6F);
            3: o = mkOp(0, 0, 3'd0, 7'h67);
            4: o = mkOp(0, 0, 3'($urandom), 7'h63);
            5: o = mkOp(0, 1'($urandom), 3'($urandom), 7'h13);
            6: o = mkOp(0, 1'($urandom), 3'($urandom), 7'h33);
            7: o = mkOp(1, 0, 3'($urandom_range(0, 3)), 7'h33);
            8: begin
               o = mkOp(1, 0, 3'($urandom_range(4, 7)), 7'h33);
               if ($urandom_range(0, 5) == 0) b = 32'd0;
               else if ($urandom_range(0, 5) == 0) begin a = 32'h8000_0000; b = 32'hFFFF_FFFF; end
            end
            default: o = mkOp(0, 0, 3'($urandom), 7'h03);
         endcase
         applyStimulus(o, a, b, p, im, 1'($urandom), 4'($urandom), 0, 32'd0);
         if ($urandom_range(0, 2) == 0) idleCycles($urandom_range(1, 2));
      end

      // drain the scoreboard
      waited = 0;
      while (sb.size() != 0 && waited < 100) begin
         @(negedge clk_in);
         waited++;
      end
      checkOutput("drain", 64'(sb.size()), 64'd0);

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule

// File: doc/exec_unit_md.md
Name: exec_unit_md

Overview:
- Parametrised successor to the single-cycle integer ALU: executes RV32I ALU/branch/jump ops plus the RV M-extension (MUL/MULH/MULHSU/MULHU/DIV/DIVU/REM/REMU).
- Sits between the ALU reservation station and the CDB/ROB writeback.
- Adds a valid/ready input handshake, a multi-cycle multiply and an iterative divider.
- Adds a flush that drops in-flight work on misprediction.

Parameters:
- XLEN, 32, datapath width; must be 32 or 64; shift amounts use imm/v2 [log2(XLEN)-1:0].
- ROB_W, 4, width of ROB tag.
- MUL_LAT, 2, cycles from accept to result for MUL*; minimum 1.

Ports:
- clk_in  in  1  clock, all state on rising edge.
- rstn_in  in  1  asynchronous, active-low reset.
- flush_in  in  1  synchronous squash of accepted and in-flight ops.
- in_valid  in  1  operation presented.
- in_ready  out  1  unit can accept this cycle.
- op  in  12  [6:0] opcode, [9:7] funct3, [10] funct7 bit5, [11] funct7 bit0 (M-ext select when opcode is R-type).
- v1, v2  in  XLEN  source operands.
- pc, imm  in  XLEN  instruction PC and sign-extended immediate.
- is_short  in  1  compressed instruction; link value = pc+2 instead of pc+4.
- in_rob_id  in  ROB_W  destination ROB tag.
- has_output  out  1  result valid, one-cycle pulse per op.
- rob_id  out  ROB_W  tag of result.
- value  out  XLEN  result; branch ops give 1/0 compare outcome.
- has_new_pc  out  1  asserted with has_output for JALR only.
- new_pc  out  XLEN  (v1+imm) & ~1 for JALR.

Behaviour:
- Reset (rstn_in low, asynchronous):
  - has_output=0, has_new_pc=0, rob_id=0, value=0, new_pc=0.
  - FSM to IDLE.
  - in_ready=1 from the first edge after release.
- Accept: in_valid && in_ready && !flush_in at a rising edge.
- FSM states:
  - IDLE: in_ready=1.
  - MUL: counter runs MUL_LAT-1 cycles; in_ready=0.
  - DIV: divide counter runs XLEN cycles; in_ready=0.
  - in_ready is combinational from state only, never from in_valid.
- Non-M ops (LUI, AUIPC, JAL, JALR, B*, OP-IMM, OP): single-cycle.
  - has_output=1 on the edge after accept; state stays IDLE; back-to-back accepts allowed.
  - Results bit-exact with the existing ALU semantics.
  - Unknown opcode: has_output=1, value=0.
- MUL*:
  - Result on edge accept+MUL_LAT.
  - MUL gives low XLEN bits; MULH/MULHSU/MULHU give high XLEN bits of the 2*XLEN product with signed×signed, signed×unsigned and unsigned×unsigned operands respectively.
- DIV*/REM*:
  - Radix-2 restoring divide on magnitudes, signs fixed at the end.
  - has_output at edge accept+XLEN+1.
  - Fast path, result at edge accept+1 with no DIV state:
    - divisor 0: DIV/DIVU give all-ones; REM/REMU give v1.
    - signed overflow (v1=most-negative, v2=-1): DIV gives v1; REM gives 0.
  - Remainder sign follows dividend; quotient truncates toward zero.
- Output pulse: has_output/has_new_pc high exactly one cycle per op, then 0. value/rob_id/new_pc hold last values; they are don't-care when has_output=0.
- flush_in high at an edge:
  - state to IDLE, counters cleared, has_output=0 and has_new_pc=0 at that edge.
  - Any single-cycle result that would have appeared is suppressed.
  - Input presented that cycle is not accepted.
  - in_ready=1 next cycle.
- Reset mid-DIV/MUL: op discarded, no output after release.
- Only one op in flight for M-ext, so the output port never conflicts; no output buffering.

Decomposition:
- Shared const header (existing opcode defines `olui..`orr): add M-ext funct3 codes and an `ROB_R range built from ROB_W.
- Sub-module div_iter: XLEN-parametrised iterative unsigned divider.
  - Inputs: start/dividend/divisor/clear. Outputs: done/quotient/remainder.
  - Owns the XLEN-cycle counter.
- Multiply stays inline as a retimed product register chain of depth MUL_LAT.

Test Plan:
- ADDI v1=5, imm=-7, rob 3 -> next cycle has_output=1, value=0xFFFFFFFE, rob_id=3, has_new_pc=0; back-to-back SUB 10-3 next cycle -> value=7.
- JALR v1=0x1001, imm=4, pc=0x100, is_short=1 -> value=0x102, has_new_pc=1, new_pc=0x1004, both for exactly one cycle.
- MULH v1=0x80000000, v2=2 (MUL_LAT=2) -> in_ready=0 one cycle, result at accept+2, value=0xFFFFFFFF; MULHU same operands -> value=1.
- DIV v1=-7, v2=2 -> in_ready low 32 cycles, has_output at accept+33, value=-3; REM same operands -> value=-1.
- DIVU v1=9, v2=0 -> value=0xFFFFFFFF at accept+1; DIV 0x80000000/-1 -> value=0x80000000; REM of the same -> value=0.
- DIV started, flush_in at cycle 10 with in_valid=1 -> no has_output ever for either op, in_ready=1 next cycle; rstn_in low mid-DIV -> outputs 0 immediately, no result after release.
